// File: rtl/imem_arbiter_pkg.sv
// rtl/imem_arbiter_pkg.sv - shared encodings for the instruction memory arbiter
package imem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_EMIT  = 1'b1;

  localparam logic RWN_READ  = 1'b1;
  localparam logic RWN_WRITE = 1'b0;

endpackage

// File: rtl/imem_arbiter_if.sv
// rtl/imem_arbiter_if.sv - requester, memory and status signals of the arbiter
interface imem_arbiter_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32
);
  logic                     f_req;
  logic [ADDRESS_WIDTH-1:0] f_addr;
  logic                     f_done;
  logic                     f_err;
  logic [DATA_WIDTH-1:0]    f_rdata;

  logic                     e_req;
  logic                     e_rwn;
  logic [ADDRESS_WIDTH-1:0] e_addr;
  logic [DATA_WIDTH-1:0]    e_wdata;
  logic                     e_done;
  logic                     e_err;
  logic [DATA_WIDTH-1:0]    e_rdata;

  logic                     mem_start;
  logic                     mem_rwn;
  logic [ADDRESS_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0]    mem_data_in;
  logic [DATA_WIDTH-1:0]    mem_data_out;
  logic                     mem_ready;

  logic                     busy;
  logic                     owner;

  modport slave (
    input  f_req, f_addr, e_req, e_rwn, e_addr, e_wdata, mem_data_out, mem_ready,
    output f_done, f_err, f_rdata, e_done, e_err, e_rdata,
           mem_start, mem_rwn, mem_address, mem_data_in, busy, owner
  );

  modport master (
    output f_req, f_addr, e_req, e_rwn, e_addr, e_wdata, mem_data_out, mem_ready,
    input  f_done, f_err, f_rdata, e_done, e_err, e_rdata,
           mem_start, mem_rwn, mem_address, mem_data_in, busy, owner
  );
endinterface

// File: rtl/imem_arbiter_watchdog_counter.sv
// rtl/imem_arbiter_watchdog_counter.sv - saturating per-transaction timeout counter
module watchdog_counter #(
  parameter int TIMEOUT = 64,
  localparam int W = $clog2(TIMEOUT)
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT - 1);

  logic [W-1:0] r_count;

  // Holds at LIMIT so a stalled memory can never wrap the count back to zero.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != LIMIT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count == LIMIT);
endmodule

// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - round-robin sequencer of fetch and emitter onto the shared memory
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int TIMEOUT       = 64
) (
  input logic           clk,
  input logic           reset,
  imem_arbiter_if.slave bus
);
  state_t                   r_state;
  logic                     r_owner;
  logic                     r_last_owner;
  logic                     r_mem_start;
  logic                     r_mem_rwn;
  logic [ADDRESS_WIDTH-1:0] r_mem_address;
  logic [DATA_WIDTH-1:0]    r_mem_data_in;
  logic                     r_f_done, r_f_err, r_e_done, r_e_err;
  logic [DATA_WIDTH-1:0]    r_f_rdata, r_e_rdata;
  logic                     r_busy;

  state_t w_next_state;
  logic   w_grant;
  logic   w_grant_owner;
  logic   w_finish;
  logic   w_timeout;
  logic   w_expired;

  watchdog_counter #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_grant),
    .i_enable  (r_state == ST_BUSY),
    .o_expired (w_expired)
  );

  always_comb begin
    w_next_state  = r_state;
    w_grant       = 1'b0;
    w_grant_owner = r_owner;
    w_finish      = 1'b0;
    w_timeout     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.f_req || bus.e_req) begin
          w_grant      = 1'b1;
          w_next_state = ST_BUSY;
          if (bus.f_req && bus.e_req) w_grant_owner = ~r_last_owner;
          else                        w_grant_owner = bus.e_req ? OWN_EMIT : OWN_FETCH;
        end
      end
      ST_BUSY: begin
        // A response arriving on the expiry cycle still counts as success.
        if (bus.mem_ready) begin
          w_finish     = 1'b1;
          w_next_state = ST_DONE;
        end else if (w_expired) begin
          w_finish     = 1'b1;
          w_timeout    = 1'b1;
          w_next_state = ST_DONE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_owner       <= OWN_FETCH;
      r_last_owner  <= OWN_EMIT;
      r_mem_start   <= 1'b0;
      r_mem_rwn     <= RWN_READ;
      r_mem_address <= '0;
      r_mem_data_in <= '0;
      r_f_done      <= 1'b0;
      r_f_err       <= 1'b0;
      r_e_done      <= 1'b0;
      r_e_err       <= 1'b0;
      r_f_rdata     <= '0;
      r_e_rdata     <= '0;
      r_busy        <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_busy   <= (w_next_state != ST_IDLE);
      r_f_done <= 1'b0;
      r_f_err  <= 1'b0;
      r_e_done <= 1'b0;
      r_e_err  <= 1'b0;
      if (w_grant) begin
        r_owner      <= w_grant_owner;
        r_last_owner <= w_grant_owner;
        r_mem_start  <= 1'b1;
        if (w_grant_owner == OWN_FETCH) begin
          r_mem_address <= bus.f_addr;
          r_mem_rwn     <= RWN_READ;
        end else begin
          r_mem_address <= bus.e_addr;
          r_mem_rwn     <= bus.e_rwn;
          r_mem_data_in <= bus.e_wdata;
        end
      end
      if (w_finish) begin
        r_mem_start <= 1'b0;
        if (r_owner == OWN_FETCH) begin
          r_f_done <= 1'b1;
          r_f_err  <= w_timeout;
          if (w_timeout)                   r_f_rdata <= '0;
          else if (r_mem_rwn == RWN_READ)  r_f_rdata <= bus.mem_data_out;
        end else begin
          r_e_done <= 1'b1;
          r_e_err  <= w_timeout;
          if (w_timeout)                   r_e_rdata <= '0;
          else if (r_mem_rwn == RWN_READ)  r_e_rdata <= bus.mem_data_out;
        end
      end
    end
  end

  assign bus.f_done      = r_f_done;
  assign bus.f_err       = r_f_err;
  assign bus.f_rdata     = r_f_rdata;
  assign bus.e_done      = r_e_done;
  assign bus.e_err       = r_e_err;
  assign bus.e_rdata     = r_e_rdata;
  assign bus.mem_start   = r_mem_start;
  assign bus.mem_rwn     = r_mem_rwn;
  assign bus.mem_address = r_mem_address;
  assign bus.mem_data_in = r_mem_data_in;
  assign bus.busy        = r_busy;
  assign bus.owner       = r_owner;
endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - directed self-checking bench for imem_arbiter
module tb_imem_arbiter;
  logic clk;
  logic reset;
  int   errors;
  int   checks;
  logic [31:0] exp_f_rdata;
  logic [31:0] exp_e_rdata;

  imem_arbiter_if #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32)) bus ();

  imem_arbiter #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    bus.f_req = 1'b0;
    bus.f_addr = '0;
    bus.e_req = 1'b0;
    bus.e_rwn = 1'b1;
    bus.e_addr = '0;
    bus.e_wdata = '0;
    bus.mem_data_out = '0;
    bus.mem_ready = 1'b0;
    tick();
    tick();

    check("rst_mem_start", bus.mem_start, 0);
    check("rst_mem_rwn", bus.mem_rwn, 1);
    check("rst_mem_address", bus.mem_address, 0);
    check("rst_mem_data_in", bus.mem_data_in, 0);
    check("rst_dones", {bus.f_done, bus.f_err, bus.e_done, bus.e_err}, 0);
    check("rst_f_rdata", bus.f_rdata, 0);
    check("rst_e_rdata", bus.e_rdata, 0);
    check("rst_busy_owner", {bus.busy, bus.owner}, 0);
    reset = 1'b0;
    tick();

    // single fetch, ready in the first BUSY cycle; f_req high in cycle 1
    bus.f_req = 1'b1;
    bus.f_addr = 8'h10;
    tick();
    check("f1_mem_start", bus.mem_start, 1);
    check("f1_mem_address", bus.mem_address, 32'h10);
    check("f1_mem_rwn", bus.mem_rwn, 1);
    check("f1_busy_owner", {bus.busy, bus.owner}, 2'b10);
    check("f1_done_early", bus.f_done, 0);
    bus.mem_ready = 1'b1;
    bus.mem_data_out = 32'hDEADBEEF;
    tick();
    check("f1_done_c3", {bus.f_done, bus.f_err, bus.e_done}, 3'b100);
    check("f1_rdata", bus.f_rdata, 32'hDEADBEEF);
    check("f1_start_low", bus.mem_start, 0);
    bus.f_req = 1'b0;
    bus.mem_ready = 1'b0;
    tick();
    check("f1_idle", {bus.busy, bus.f_done, bus.mem_start}, 0);
    exp_f_rdata = 32'hDEADBEEF;
    exp_e_rdata = 32'h0;

    // emitter write, ready in the fourth BUSY cycle
    bus.e_req = 1'b1;
    bus.e_rwn = 1'b0;
    bus.e_addr = 8'h20;
    bus.e_wdata = 32'h12345678;
    bus.mem_data_out = 32'hFFFF0000;
    tick();
    check("e_mem_rwn", bus.mem_rwn, 0);
    check("e_mem_data_in", bus.mem_data_in, 32'h12345678);
    check("e_mem_address", bus.mem_address, 32'h20);
    check("e_owner", bus.owner, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("e_wait", {bus.mem_start, bus.e_done}, 2'b10);
    end
    bus.mem_ready = 1'b1;
    tick();
    check("e_done", {bus.e_done, bus.e_err, bus.f_done}, 3'b100);
    check("e_rdata_kept", bus.e_rdata, exp_e_rdata);
    check("e_f_rdata_kept", bus.f_rdata, exp_f_rdata);
    bus.e_req = 1'b0;
    bus.mem_ready = 1'b0;
    tick();
    check("e_idle", {bus.busy, bus.e_done}, 0);

    // both held: fetch, emit, fetch, emit with an IDLE cycle between each
    bus.f_req = 1'b1;
    bus.f_addr = 8'h30;
    bus.e_req = 1'b1;
    bus.e_rwn = 1'b1;
    bus.e_addr = 8'h40;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic exp_owner;
      exp_owner = (i % 2 == 1);
      bus.mem_data_out = 32'hA0 + i;
      tick();
      check("rr_owner", bus.owner, exp_owner);
      check("rr_busy_start", {bus.busy, bus.mem_start}, 2'b11);
      check("rr_address", bus.mem_address, exp_owner ? 32'h40 : 32'h30);
      tick();
      if (exp_owner) exp_e_rdata = 32'hA0 + i;
      else           exp_f_rdata = 32'hA0 + i;
      check("rr_dones", {bus.f_done, bus.e_done}, exp_owner ? 2'b01 : 2'b10);
      check("rr_f_rdata", bus.f_rdata, exp_f_rdata);
      check("rr_e_rdata", bus.e_rdata, exp_e_rdata);
      if (i == 3) begin
        bus.f_req = 1'b0;
        bus.e_req = 1'b0;
      end
      tick();
      check("rr_idle_gap", {bus.busy, bus.mem_start}, 0);
    end
    bus.mem_ready = 1'b0;

    // timeout with TIMEOUT = 8: mem_start in cycle 1, done+err in cycle 9
    bus.f_req = 1'b1;
    bus.f_addr = 8'h55;
    tick();
    check("to_start", bus.mem_start, 1);
    for (int i = 2; i <= 8; i++) begin
      tick();
      check("to_wait", {bus.mem_start, bus.f_done}, 2'b10);
    end
    tick();
    check("to_done_err", {bus.f_done, bus.f_err}, 2'b11);
    check("to_rdata", bus.f_rdata, 0);
    check("to_start_low", bus.mem_start, 0);
    bus.f_req = 1'b0;
    tick();
    check("to_idle", {bus.busy, bus.f_done, bus.f_err}, 0);

    // reset in the second BUSY cycle drops the transaction
    bus.e_req = 1'b1;
    bus.e_rwn = 1'b1;
    bus.e_addr = 8'h66;
    tick();
    tick();
    check("rb_busy2", {bus.busy, bus.mem_start, bus.owner}, 3'b111);
    reset = 1'b1;
    tick();
    check("rb_dropped", {bus.mem_start, bus.busy, bus.e_done}, 0);
    reset = 1'b0;
    bus.e_req = 1'b0;
    tick();
    check("rb_no_done", {bus.e_done, bus.f_done, bus.busy}, 0);
    bus.f_req = 1'b1;
    bus.f_addr = 8'h77;
    bus.e_req = 1'b1;
    bus.e_addr = 8'h78;
    tick();
    check("rb_tie_owner", bus.owner, 0);
    check("rb_tie_address", bus.mem_address, 32'h77);
    bus.f_req = 1'b0;
    bus.e_req = 1'b0;
    bus.mem_ready = 1'b1;
    bus.mem_data_out = 32'h0BADF00D;
    tick();
    check("rb_tie_done", {bus.f_done, bus.e_done}, 2'b10);
    check("rb_tie_rdata", bus.f_rdata, 32'h0BADF00D);
    bus.mem_ready = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Two-requester arbiter and sequencer for the single shared instruction memory. It serialises transactions from the bytecode fetch unit (read-only) and the ARM code emitter (read/write) onto the memory's start/ready handshake, using round-robin grant and a per-transaction watchdog timeout. It sits between both requesters and the `memory` instance and is the only driver of the memory's `start`, `address`, `rwn` and `data_in`.

## Interface

Parameters:
- `ADDRESS_WIDTH`, default 8: memory address width.
- `DATA_WIDTH`, default 32: memory word width.
- `TIMEOUT`, default 64: maximum number of BUSY cycles spent waiting for `mem_ready` before the transaction is aborted. Must be ≥ 2.

Ports (clock and reset first):
- `clk` in 1: the single clock; every register updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `f_req` in 1: fetch request; held high until `f_done`.
- `f_addr` in ADDRESS_WIDTH: fetch address; stable while `f_req` is high.
- `f_done` out 1: one-cycle completion pulse for the fetch requester.
- `f_err` out 1: qualifies `f_done`; high means the transaction timed out.
- `f_rdata` out DATA_WIDTH: fetch read data; valid while `f_done` is high.
- `e_req` in 1: emitter request; held high until `e_done`.
- `e_rwn` in 1: emitter direction; 1 = read, 0 = write.
- `e_addr` in ADDRESS_WIDTH: emitter address.
- `e_wdata` in DATA_WIDTH: emitter write data.
- `e_done`, `e_err`, `e_rdata` out (1, 1, DATA_WIDTH): as for the fetch requester.
- `mem_start` out 1: memory transaction strobe.
- `mem_rwn` out 1: memory direction.
- `mem_address` out ADDRESS_WIDTH: memory address.
- `mem_data_in` out DATA_WIDTH: memory write data.
- `mem_data_out` in DATA_WIDTH: memory read data.
- `mem_ready` in 1: memory completion; read data is valid in the same cycle.
- `busy` out 1: high in BUSY and DONE.
- `owner` out 1: current owner; 0 = fetch, 1 = emitter.

## Operation

- Three states: IDLE, BUSY, DONE. All outputs are registered.
- **IDLE**
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requesting: grant the requester that was not granted last; `last_owner` resets to emitter, so fetch wins the first tie.
  - On grant: latch owner, address, rwn and write data (fetch forces rwn = 1), update `last_owner`, clear the watchdog, go to BUSY.
- **BUSY**
  - `mem_start` = 1 and the memory outputs are driven from the latched registers.
  - `mem_ready` sampled high: capture `mem_data_out` into the owner's rdata register; go to DONE with err = 0.
  - Watchdog reaches TIMEOUT-1 without `mem_ready`: go to DONE with err = 1 and the owner's rdata = 0.
  - A requester that drops `req` during BUSY is a protocol violation. The transaction still completes and `done` still pulses.
- **DONE**
  - The owner's `done` = 1 for exactly this cycle, with its `err`; `mem_start` = 0.
  - Requests are ignored in this cycle. Next state is always IDLE.
- Non-owner `done`/`err` stay 0. Non-owner rdata holds its last value.
- On a write, the owner's rdata is unchanged.
- Reset values:
  - state IDLE; `mem_start` 0; `mem_rwn` 1; `mem_address` 0; `mem_data_in` 0.
  - all `done` and `err` 0; both rdata 0.
  - `busy` 0; `owner` 0; `last_owner` 1; watchdog 0.
- `reset` during BUSY or DONE: the transaction is dropped, with no `done` pulse, and the next state is IDLE.

## Timing

- Request seen high at edge k (IDLE): `mem_start` is high from cycle k+1.
- `mem_ready` sampled at edge m: `done` is high during cycle m+1, and `mem_start` is low from cycle m+1.
- Minimum transaction latency: `req` high → `done` high in 3 cycles, when `mem_ready` is returned in the first BUSY cycle.
- Back-to-back transactions: at least one IDLE cycle after DONE, so the next `mem_start` rises no earlier than 2 cycles after `done`.
- Timeout: `done` with `err` appears TIMEOUT+1 cycles after `mem_start` rises.
- Watchdog counter width is $clog2(TIMEOUT); it saturates and never wraps.

## Structure

- Shared package holds:
  - the state encoding ST_IDLE/ST_BUSY/ST_DONE;
  - the owner encoding OWN_FETCH = 0, OWN_EMIT = 1;
  - the rwn constants RWN_READ = 1, RWN_WRITE = 0.
- One sub-module, `watchdog_counter`:
  - clear, enable, saturating count;
  - `expired` output at TIMEOUT-1.
- The round-robin pick stays inline.

## Test plan

- Single fetch at address 0x10; memory returns 0xDEADBEEF with `mem_ready` in the first BUSY cycle → `mem_address` = 0x10, `mem_rwn` = 1; `f_done` high 3 cycles after `f_req` rises; `f_rdata` = 0xDEADBEEF; `f_err` = 0.
- Emitter write, address 0x20, data 0x12345678; `mem_ready` after 4 cycles → `mem_rwn` = 0, `mem_data_in` = 0x12345678; `e_done` pulse; `e_rdata` unchanged.
- Both requests held continuously for 4 transactions → grants in the order fetch, emit, fetch, emit; `owner` toggles each time; one IDLE cycle between each DONE and the next BUSY.
- TIMEOUT = 8 and `mem_ready` never asserted → `f_done` and `f_err` both high 9 cycles after `mem_start` rises; `f_rdata` = 0; the arbiter returns to IDLE.
- `reset` asserted in the 2nd BUSY cycle → next cycle `mem_start` = 0, `busy` = 0, no `done` pulse; a subsequent tie is granted to fetch.
